// File: rtl/uart_rx_fifo_if.sv
// Bus-side bundle of the UART receive FIFO: push strobe, pop request,
// status and the first-word-fall-through head word.
interface uart_rx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int ADDR_W = $clog2(DEPTH);

    // Handshake: wb_stb pushes uart_rx with no back-pressure (a push into a
    // full FIFO is dropped and flagged on overflow unless rd_en frees a slot
    // in the same cycle); !empty is the valid for data_reg, and rd_en pops
    // the head only when !empty, otherwise it is ignored.
    logic              wb_stb;
    logic [DATA_W-1:0] uart_rx;
    logic              rd_en;
    logic              ovf_clr;
    logic              alarm_clr;
    logic [DATA_W-1:0] data_reg;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              seq_alarm;

    modport master (
        output wb_stb, uart_rx, rd_en, ovf_clr, alarm_clr,
        input  data_reg, empty, full, count, overflow, seq_alarm
    );

    modport slave (
        input  wb_stb, uart_rx, rd_en, ovf_clr, alarm_clr,
        output data_reg, empty, full, count, overflow, seq_alarm
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: DEPTH-entry FWFT queue with occupancy status, sticky
// overflow and an optional consecutive-match alarm (UART_RX_FIFO_SEQ_ALARM_EN).
module uart_rx_fifo #(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 8,
    parameter logic [DATA_W-1:0] MATCH_VAL = DATA_W'(8'hAF),
    parameter int                MATCH_CNT = 3
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fifo_if.slave bus
);
    localparam int              ADDR_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;
    logic              empty_w;
    logic              full_w;
    logic              pop_acc;
    logic              wr_acc;
    logic              drop;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == FULL_CNT);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign pop_acc = bus.rd_en && !empty_w;
    assign wr_acc  = bus.wb_stb && (!full_w || pop_acc);
    assign drop    = bus.wb_stb && !wr_acc;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.uart_rx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, pop_acc})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign bus.data_reg = empty_w ? '0 : mem[rd_ptr];
    assign bus.empty    = empty_w;
    assign bus.full     = full_w;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

`ifdef UART_RX_FIFO_SEQ_ALARM_EN
    localparam int              MC_W      = $clog2(MATCH_CNT + 1);
    localparam logic [MC_W-1:0] MATCH_TOP = MC_W'(MATCH_CNT);
    localparam logic [MC_W-1:0] MC_ONE    = MC_W'(1);

    logic [MC_W-1:0] match_cnt;
    logic [MC_W-1:0] match_next;
    logic            match_hit;
    logic            raise;
    logic            alarm_q;

    // Only accepted writes are observed; dropped words do not break a run.
    always_comb begin
        match_hit  = wr_acc && (bus.uart_rx == MATCH_VAL);
        match_next = (match_cnt == MATCH_TOP) ? MATCH_TOP : match_cnt + MC_ONE;
        raise      = match_hit && (match_next == MATCH_TOP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_cnt <= '0;
            alarm_q   <= 1'b0;
        end else if (raise) begin
            match_cnt <= match_next;
            alarm_q   <= 1'b1;
        end else if (bus.alarm_clr) begin
            match_cnt <= '0;
            alarm_q   <= 1'b0;
        end else if (wr_acc) begin
            match_cnt <= match_hit ? match_next : '0;
        end
    end

    assign bus.seq_alarm = alarm_q;
`else
    logic unused_alarm;
    assign unused_alarm  = ^{bus.alarm_clr, MATCH_VAL, 32'(MATCH_CNT)};
    assign bus.seq_alarm = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo against a queue-based
// reference model of the receive FIFO and its pattern alarm.
module tb_uart_rx_fifo;
    localparam int         DATA_W    = 8;
    localparam int         DEPTH     = 8;
    localparam int         MATCH_CNT = 3;
    localparam logic [7:0] MATCH_VAL = 8'hAF;
`ifdef UART_RX_FIFO_SEQ_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    uart_rx_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .MATCH_VAL(MATCH_VAL),
        .MATCH_CNT(MATCH_CNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] exp_q[$];
    bit m_ovf   = 1'b0;
    bit m_alarm = 1'b0;
    int m_run   = 0;
    int total   = 0;
    int bad     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DATA_W-1:0] head;
        head = (exp_q.size() == 0) ? '0 : exp_q[0];
        chk({tag, ".data"},  32'(bus.data_reg),  32'(head));
        chk({tag, ".count"}, 32'(bus.count),     32'(exp_q.size()));
        chk({tag, ".empty"}, 32'(bus.empty),     32'(exp_q.size() == 0));
        chk({tag, ".full"},  32'(bus.full),      32'(exp_q.size() == DEPTH));
        chk({tag, ".ovf"},   32'(bus.overflow),  32'(m_ovf));
        chk({tag, ".alarm"}, 32'(bus.seq_alarm), 32'(m_alarm));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf   = 1'b0;
        m_alarm = 1'b0;
        m_run   = 0;
    endtask

    task automatic set_idle();
        bus.wb_stb    = 1'b0;
        bus.uart_rx   = '0;
        bus.rd_en     = 1'b0;
        bus.ovf_clr   = 1'b0;
        bus.alarm_clr = 1'b0;
    endtask

    // One clock with the given inputs; the model is updated from the
    // FIFO rules, then every output is compared just after the edge.
    task automatic cycle(input string tag, input logic stb, input logic [DATA_W-1:0] d,
                         input logic rd, input logic oc, input logic ac);
        bit pop, wr, drop, raise;
        bus.wb_stb    = stb;
        bus.uart_rx   = d;
        bus.rd_en     = rd;
        bus.ovf_clr   = oc;
        bus.alarm_clr = ac;
        pop  = rd && (exp_q.size() != 0);
        wr   = stb && ((exp_q.size() < DEPTH) || pop);
        drop = stb && !wr;
        @(posedge clk);
        #1;
        if (pop) void'(exp_q.pop_front());
        if (wr) exp_q.push_back(d);
        if (drop) m_ovf = 1'b1;
        else if (oc) m_ovf = 1'b0;
        if (ALARM_ON) begin
            raise = 1'b0;
            if (wr) begin
                if (d == MATCH_VAL) begin
                    if (m_run < MATCH_CNT) m_run++;
                    raise = (m_run == MATCH_CNT);
                end else begin
                    m_run = 0;
                end
            end
            if (raise) m_alarm = 1'b1;
            else if (ac) begin
                m_alarm = 1'b0;
                m_run   = 0;
            end
        end
        set_idle();
        check_all(tag);
    endtask

    initial begin
        logic [DATA_W-1:0] seq [6];
        seq = '{8'hAF, 8'hAF, 8'h81, 8'hAF, 8'hAF, 8'hAF};
        set_idle();
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        rst = 1'b1;

        cycle("wr11", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        cycle("wr55", 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        cycle("wrA5", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle("pop3", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        cycle("drop_ff", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < DEPTH; i++) cycle("refill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        cycle("full_wr_rd", 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle("drain3c", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        cycle("empty_wr_rd", 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0);
        repeat (4) cycle("rd_empty", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) cycle("alarm_seq", 1'b1, seq[i], 1'b0, 1'b0, 1'b0);
        cycle("post_f0", 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
        repeat (7) cycle("alarm_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle("alarm_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        repeat (400) begin
            logic [DATA_W-1:0] d;
            d = ($urandom_range(0, 1) == 0) ? MATCH_VAL : 8'($urandom_range(0, 255));
            cycle("rand", 1'($urandom_range(0, 99) < 60), d, 1'($urandom_range(0, 99) < 45),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 31) == 0));
        end

        for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle("post_rst", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised successor to the single-register UART receive path.
- Wishbone-strobed receive words go into a DEPTH-entry first-word-fall-through FIFO instead of overwriting one data register.
- Adds full/empty/count status, a sticky overflow flag and an optional consecutive-pattern alarm monitor.
- Sits between the UART byte deserialiser and the bus-side consumer.

Parameters:
- DATA_W, 8, width of each received word.
- DEPTH, 8, FIFO entries; must be a power of 2 and ≥ 2.
- ADDR_W, $clog2(DEPTH), pointer width (derived; do not override).
- MATCH_VAL, 8'hAF, word value watched by the alarm monitor (DATA_W bits).
- MATCH_CNT, 3, number of consecutive accepted matches that raises the alarm; must be ≥ 1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_stb  in  1  write strobe; when high, uart_rx is sampled at that edge.
- uart_rx  in  DATA_W  received word to enqueue.
- rd_en  in  1  pop request for the head entry.
- ovf_clr  in  1  clears overflow.
- alarm_clr  in  1  clears seq_alarm and the match counter.
- data_reg  out  DATA_W  head-of-FIFO word; 0 when empty.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds DEPTH entries.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a write was dropped.
- seq_alarm  out  1  sticky; pattern sequence detected.

Behaviour:
- Reset (rst=0, asynchronous): rd_ptr=wr_ptr=0, count=0, empty=1, full=0, overflow=0, seq_alarm=0, match counter=0, data_reg=0. Memory contents are not reset.
- Pointers are ADDR_W bits, wrap from DEPTH-1 to 0. count is held explicitly; empty = (count==0), full = (count==DEPTH).
- Write accept: wb_stb=1 and (!full or pop accepted in the same cycle). mem[wr_ptr] ← uart_rx, wr_ptr increments.
- Pop accept: rd_en=1 and !empty. rd_ptr increments.
- count update per edge:
  - +1 on write accept only.
  - −1 on pop accept only.
  - Unchanged on both or neither.
- Full with wb_stb=1 and rd_en=1: pop and write both accepted, count stays DEPTH, overflow not set.
- Full with wb_stb=1 and rd_en=0: word dropped, overflow ← 1, no state change otherwise.
- Empty with rd_en=1: ignored, no underflow, count stays 0. If wb_stb=1 in the same cycle, the write is accepted and count becomes 1.
- data_reg is combinational from registered state: empty ? 0 : mem[rd_ptr]. Latency: a word written at edge N into an empty FIFO appears on data_reg right after edge N (FWFT, one-edge latency).
- ovf_clr=1: overflow ← 0 at the edge. If a drop occurs in the same cycle, set wins.
- Reset mid-operation discards all contents; status returns to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: UART_RX_FIFO_SEQ_ALARM_EN.
- Defined: a match counter of width $clog2(MATCH_CNT+1).
  - Each accepted write with uart_rx==MATCH_VAL increments the counter, saturating at MATCH_CNT.
  - An accepted non-matching write resets the counter to 0.
  - Dropped writes and wb_stb=0 cycles leave the counter unchanged.
  - When the counter reaches MATCH_CNT, seq_alarm ← 1 (sticky). This happens at the edge of the MATCH_CNT-th match.
  - alarm_clr=1 clears both seq_alarm and the counter; an alarm-raising write in the same cycle wins.
  - Stored data is never modified; the monitor is observation only.
- Not defined: no counter logic, seq_alarm tied to 0, alarm_clr ignored.

Test Plan:
- Reset 4 edges, deassert; write 0x11, 0x55, 0xA5 on three separate cycles.
  - Expect data_reg=0x11, count=3.
  - Pop ×3 → data_reg shows 0x55, then 0xA5, then 0; empty=1, count=0.
- Fill DEPTH=8 with 0x00..0x07, then wb_stb with 0xFF.
  - Expect full=1, overflow=1, count=8; popping 8 yields 0x00..0x07 in order (0xFF absent).
  - Pulse ovf_clr → overflow=0.
- With FIFO full, assert wb_stb=1 (0x3C) and rd_en=1 in the same cycle.
  - Expect count stays 8, overflow=0, head advances by 1.
  - 0x3C appears as the last entry after 7 further pops.
- Empty FIFO, rd_en=1 and wb_stb=1 (0xF0) in the same cycle.
  - Expect count=1, data_reg=0xF0, no underflow.
  - Keep rd_en=1 with wb_stb=0 for several cycles → count stays 0, data_reg=0.
- SEQ_ALARM_EN defined: write 0xAF, 0xAF, 0x81, 0xAF, 0xAF, 0xAF.
  - Expect seq_alarm=0 through the 5th write; =1 right after the 6th edge.
  - Data popped unchanged (0xF0 stays 0xF0 if written afterwards).
  - alarm_clr → seq_alarm=0.
- Macro undefined: same sequence → seq_alarm stays 0 throughout; FIFO contents identical.
